mem_rr_arbiter: RTL

Round-robin arbiter that shares one external data-memory channel among NUM_CONSUMERS LSU-style requesters. Each requester uses the same valid/ready read and write handshake the cores' LSUs already use. The arbiter sits between the LSU ports and a single memory channel. It serializes requests fairly, relays read data back, and holds each transaction open until the requester releases it.

---
 rtl/mem_rr_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin share of one memory channel among NUM_CONSUMERS LSU ports.
// Latency: request seen in IDLE -> mem valid next cycle; mem ready -> consumer ready next cycle.
// Backpressure: the served consumer's ready is held until it drops its valid; others wait for the next IDLE scan.
// Optional watchdog: define ARB_WATCHDOG_EN to bound the wait for memory ready to TIMEOUT_CYCLES.
module mem_rr_arbiter #(
  parameter int NUM_CONSUMERS  = 4,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic                                    mem_read_valid,
  output logic [ADDR_BITS-1:0]                    mem_read_address,
  input  logic                                    mem_read_ready,
  input  logic [DATA_BITS-1:0]                    mem_read_data,
  output logic                                    mem_write_valid,
  output logic [ADDR_BITS-1:0]                    mem_write_address,
  output logic [DATA_BITS-1:0]                    mem_write_data,
  input  logic                                    mem_write_ready,
  output logic                                    timeout_err
);

  localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_READ_WAIT  = 2'd1;
  localparam logic [1:0] S_WRITE_WAIT = 2'd2;
  localparam logic [1:0] S_RELAY      = 2'd3;

  logic [1:0]                                state_q, state_d;
  logic [IW-1:0]                             ptr_q, ptr_d;
  logic [IW-1:0]                             gnt_q, gnt_d;
  logic                                      op_wr_q, op_wr_d;
  logic                                      mrv_q, mrv_d;
  logic                                      mwv_q, mwv_d;
  logic [ADDR_BITS-1:0]                      mra_q, mra_d;
  logic [ADDR_BITS-1:0]                      mwa_q, mwa_d;
  logic [DATA_BITS-1:0]                      mwd_q, mwd_d;
  logic [NUM_CONSUMERS-1:0]                  rd_rdy_q, rd_rdy_d;
  logic [NUM_CONSUMERS-1:0]                  wr_rdy_q, wr_rdy_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   rd_data_q, rd_data_d;

  logic [NUM_CONSUMERS-1:0] pending;
  logic                     found;
  logic [IW-1:0]            sel;
  logic [IW-1:0]            gnt_next;
  logic                     served_vld;
  logic                     timeout_hit;

  assign pending = consumer_read_valid | consumer_write_valid;

  // Pointer after the current grant: wraps back to consumer 0.
  assign gnt_next = (int'(gnt_q) == NUM_CONSUMERS - 1) ? '0 : gnt_q + 1'b1;

  // Valid currently being served by the granted consumer; its drop ends RELAY.
  assign served_vld = op_wr_q ? consumer_write_valid[gnt_q] : consumer_read_valid[gnt_q];

  // First pending consumer at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      int k;
      k = (int'(ptr_q) + i) % NUM_CONSUMERS;
      if (!found && pending[k]) begin
        found = 1'b1;
        sel   = IW'(k);
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt_q;
  logic          err_q;
  logic          waiting;
  logic          mem_done;

  assign waiting     = (state_q == S_READ_WAIT) || (state_q == S_WRITE_WAIT);
  assign mem_done    = (state_q == S_READ_WAIT) ? mem_read_ready : mem_write_ready;
  // A real memory response in the same cycle as expiry wins over the timeout.
  assign timeout_hit = waiting && !mem_done && (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = err_q;

  // Watchdog counter restarts on every entry to a wait state; error is sticky until reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= (waiting && !mem_done && !timeout_hit) ? wd_cnt_q + 1'b1 : '0;
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Arbitration FSM next-state and output-register next values.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    op_wr_d   = op_wr_q;
    mrv_d     = mrv_q;
    mwv_d     = mwv_q;
    mra_d     = mra_q;
    mwa_d     = mwa_q;
    mwd_d     = mwd_q;
    rd_rdy_d  = rd_rdy_q;
    wr_rdy_d  = wr_rdy_q;
    rd_data_d = rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d = sel;
          // Reads take priority when a consumer asks for both.
          if (consumer_read_valid[sel]) begin
            op_wr_d = 1'b0;
            mrv_d   = 1'b1;
            mra_d   = consumer_read_address[sel];
            state_d = S_READ_WAIT;
          end else begin
            op_wr_d = 1'b1;
            mwv_d   = 1'b1;
            mwa_d   = consumer_write_address[sel];
            mwd_d   = consumer_write_data[sel];
            state_d = S_WRITE_WAIT;
          end
        end
      end
      S_READ_WAIT: begin
        if (mem_read_ready || timeout_hit) begin
          mrv_d            = 1'b0;
          rd_data_d[gnt_q] = mem_read_ready ? mem_read_data : '1;
          rd_rdy_d[gnt_q]  = 1'b1;
          state_d          = S_RELAY;
        end
      end
      S_WRITE_WAIT: begin
        if (mem_write_ready || timeout_hit) begin
          mwv_d           = 1'b0;
          wr_rdy_d[gnt_q] = 1'b1;
          state_d         = S_RELAY;
        end
      end
      S_RELAY: begin
        if (!served_vld) begin
          rd_rdy_d = '0;
          wr_rdy_d = '0;
          ptr_d    = gnt_next;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transaction without a completion pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      op_wr_q   <= 1'b0;
      mrv_q     <= 1'b0;
      mwv_q     <= 1'b0;
      mra_q     <= '0;
      mwa_q     <= '0;
      mwd_q     <= '0;
      rd_rdy_q  <= '0;
      wr_rdy_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      op_wr_q   <= op_wr_d;
      mrv_q     <= mrv_d;
      mwv_q     <= mwv_d;
      mra_q     <= mra_d;
      mwa_q     <= mwa_d;
      mwd_q     <= mwd_d;
      rd_rdy_q  <= rd_rdy_d;
      wr_rdy_q  <= wr_rdy_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign consumer_read_ready  = rd_rdy_q;
  assign consumer_write_ready = wr_rdy_q;
  assign consumer_read_data   = rd_data_q;
  assign mem_read_valid       = mrv_q;
  assign mem_read_address     = mra_q;
  assign mem_write_valid      = mwv_q;
  assign mem_write_address    = mwa_q;
  assign mem_write_data       = mwd_q;

endmodule
